stopwatch_btn_ctrl: RTL and testbench
=====================================

Name: stopwatch_btn_ctrl

Overview:
Front-end control block for my_stopwatch. It takes the raw push-buttons from the board and turns them into the run, clear and lap commands the stopwatch core consumes. Each button is synchronized and debounced, and long presses are detected. A 4-state control FSM then drives level and pulse outputs. It sits between the board button pins and the stopwatch core, in the 125 MHz clock domain.

Parameters:
DB_CYCLES, 2500000, cycles an input must stay stable before it is accepted (20 ms at 125 MHz); minimum 2.
LONG_CYCLES, 125000000, cycles start must be held (debounced) to count as a long press (1 s); must be greater than DB_CYCLES.

Ports:
clk  input  1  system clock, 125 MHz
rst  input  1  asynchronous, active-low reset
btn_start  input  1  raw start/stop button, active-high, asynchronous to clk, bouncy
btn_lap  input  1  raw lap/clear button, active-high, asynchronous to clk, bouncy
run  output  1  level; 1 while the stopwatch must count
clear_pulse  output  1  one-cycle pulse; the core zeroes its time
lap_pulse  output  1  one-cycle pulse; the core captures the lap time
lap_hold  output  1  level; 1 while the display shows the frozen lap value
state  output  2  FSM state for debug/LEDs: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - run, clear_pulse, lap_pulse, lap_hold all 0.
  - Synchronizer flops, debounced levels and all counters are 0.
  - Pressing a button during reset has no effect after release.
- Input path, per button:
  - 2-flop synchronizer feeds a debounce stage.
  - The debounce counter clears whenever the synchronized input equals the debounced level. Otherwise it increments.
  - When the counter reaches DB_CYCLES-1, the debounced level flips and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never changes the debounced level.
- Press event: a one-cycle pulse on a 0->1 transition of the debounced level. A release produces no event.
- Latency: a raw level held steady propagates to the FSM in exactly DB_CYCLES+3 clk edges, counted from the first edge that samples the new raw level to the edge where state/outputs change.
- Long press:
  - A counter runs while the debounced start level is 1 and clears on release.
  - At count LONG_CYCLES-1 it emits one long event. It then saturates, with no repeat until release.
- FSM transitions (registered; outputs registered, changing on the same edge as state):
  - IDLE: start -> RUN. Lap is ignored.
  - RUN: start -> PAUSE. Lap -> LAP, with lap_pulse=1 for one cycle.
  - LAP: lap -> RUN. Start -> PAUSE, and lap_hold clears.
  - PAUSE: start -> RUN. Lap -> IDLE, with clear_pulse=1 for one cycle.
  - Long event, from any state: -> IDLE with clear_pulse=1 for one cycle. The short-press action on the initial press edge has already taken effect.
- Output decode:
  - run = 1 in RUN and LAP.
  - lap_hold = 1 only in LAP.
  - state reflects the current FSM state.
- Priority for same-cycle events: long > start > lap. A lower-priority event in the same cycle is dropped, not queued.
- clear_pulse and lap_pulse are never both 1 in the same cycle. Neither is ever wider than one cycle.
- A held button generates exactly one press event. Repeat requires release (debounced) and a new press.

Test Plan:
All scenarios use DB_CYCLES=4 and LONG_CYCLES=32.
1. Reset, then a clean btn_start press of 10 cycles -> state 00->01 exactly 7 edges after the first sampling edge; run=1; no pulses.
2. In RUN, btn_start bounces 1-0-1-0-1 with each segment 2 cycles, then held 1 -> exactly one transition RUN->PAUSE; run=0.
3. RUN, lap press -> state=11, lap_pulse high 1 cycle, lap_hold=1, run=1; second lap press -> state=01, lap_hold=0, no second lap_pulse.
4. PAUSE, lap press -> state=00, clear_pulse high exactly 1 cycle; a further lap press in IDLE -> no change, no pulses.
5. RUN, start held 40 cycles -> PAUSE after the debounce latency; then at hold count 32 -> IDLE with one clear_pulse; held 20 more cycles -> no further events.
6. Both buttons rise on the same cycle in RUN -> PAUSE, no lap_pulse. Mid-debounce of a start press in RUN, rst driven 0 for 3 cycles -> all outputs 0 immediately (asynchronously); after release, state stays 00 with no spurious event.

Source files
------------

// File: rtl/stopwatch_btn_ctrl.sv
// rtl/stopwatch_btn_ctrl.sv - button synchronizer/debouncer, long-press detect and stopwatch control FSM
module stopwatch_btn_ctrl #(
    parameter int DB_CYCLES   = 2500000,
    parameter int LONG_CYCLES = 125000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       run,
    output logic       clear_pulse,
    output logic       lap_pulse,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int LGW = $clog2(LONG_CYCLES);
    localparam logic [DBW-1:0] DB_MAX   = DBW'(DB_CYCLES - 1);
    localparam logic [LGW-1:0] LONG_MAX = LGW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    // Bit 0 is the start button, bit 1 the lap button.
    logic [1:0]     sync1, sync2, db, db_q;
    logic [DBW-1:0] db_cnt [2];
    logic [LGW-1:0] long_cnt;
    logic           long_done;
    logic           start_ev, lap_ev, long_ev;

    state_t cur, nxt;
    logic   clr_nxt, lap_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            db_q      <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {btn_lap, btn_start};
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign start_ev = db[0] & ~db_q[0];
    assign lap_ev   = db[1] & ~db_q[1];
    assign long_ev  = db[0] & (long_cnt == LONG_MAX) & ~long_done;

    // Counter saturates at its terminal value; long_done blocks repeats until release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_cnt  <= '0;
            long_done <= 1'b0;
        end else if (!db[0]) begin
            long_cnt  <= '0;
            long_done <= 1'b0;
        end else begin
            if (long_cnt != LONG_MAX)
                long_cnt <= long_cnt + 1'b1;
            if (long_ev)
                long_done <= 1'b1;
        end
    end

    always_comb begin
        nxt     = cur;
        clr_nxt = 1'b0;
        lap_nxt = 1'b0;
        if (long_ev) begin
            nxt     = IDLE;
            clr_nxt = 1'b1;
        end else if (start_ev) begin
            case (cur)
                IDLE:    nxt = RUN;
                RUN:     nxt = PAUSE;
                LAP:     nxt = PAUSE;
                default: nxt = RUN;
            endcase
        end else if (lap_ev) begin
            case (cur)
                RUN: begin
                    nxt     = LAP;
                    lap_nxt = 1'b1;
                end
                LAP:   nxt = RUN;
                PAUSE: begin
                    nxt     = IDLE;
                    clr_nxt = 1'b1;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= IDLE;
            run         <= 1'b0;
            lap_hold    <= 1'b0;
            clear_pulse <= 1'b0;
            lap_pulse   <= 1'b0;
        end else begin
            cur         <= nxt;
            run         <= (nxt == RUN) || (nxt == LAP);
            lap_hold    <= (nxt == LAP);
            clear_pulse <= clr_nxt;
            lap_pulse   <= lap_nxt;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// tb/tb_stopwatch_btn_ctrl.sv - directed self-checking bench for stopwatch_btn_ctrl
module tb_stopwatch_btn_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_start;
    logic       btn_lap;
    logic       run;
    logic       clear_pulse;
    logic       lap_pulse;
    logic       lap_hold;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    int lap_cnt   = 0;
    int clr_cnt   = 0;
    int trans_cnt = 0;
    int wide_cnt  = 0;
    int both_cnt  = 0;
    logic [1:0] prev_state = 2'b00;
    logic       prev_clr   = 1'b0;
    logic       prev_lap   = 1'b0;

    int lap0, clr0, tr0;

    stopwatch_btn_ctrl #(
        .DB_CYCLES  (4),
        .LONG_CYCLES(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .run        (run),
        .clear_pulse(clear_pulse),
        .lap_pulse  (lap_pulse),
        .lap_hold   (lap_hold),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #2;
        if (lap_pulse) lap_cnt++;
        if (clear_pulse) clr_cnt++;
        if (lap_pulse && clear_pulse) both_cnt++;
        if ((lap_pulse && prev_lap) || (clear_pulse && prev_clr)) wide_cnt++;
        if (state != prev_state) trans_cnt++;
        prev_state = state;
        prev_lap   = lap_pulse;
        prev_clr   = clear_pulse;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic s, input logic l, input int hold);
        btn_start = s;
        btn_lap   = l;
        tick(hold);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        tick(12);
    endtask

    initial begin
        rst       = 1'b0;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        tick(3);
        check("reset_state", 32'(state), 32'd0);
        check("reset_run", 32'(run), 32'd0);
        check("reset_pulses", 32'({clear_pulse, lap_pulse}), 32'd0);
        check("reset_lap_hold", 32'(lap_hold), 32'd0);
        rst = 1'b1;
        tick(2);

        // 1: clean start press, latency of 7 edges
        btn_start = 1'b1;
        tick(6);
        check("t1_before_latency", 32'(state), 32'd0);
        tick(1);
        check("t1_state_run", 32'(state), 32'd1);
        check("t1_run", 32'(run), 32'd1);
        tick(3);
        btn_start = 1'b0;
        tick(12);
        check("t1_no_pulses", 32'(lap_cnt + clr_cnt), 32'd0);

        // 2: bouncy start in RUN
        tr0 = trans_cnt;
        for (int i = 0; i < 4; i++) begin
            btn_start = (i % 2 == 0);
            tick(2);
        end
        btn_start = 1'b1;
        tick(10);
        btn_start = 1'b0;
        tick(12);
        check("t2_one_transition", 32'(trans_cnt - tr0), 32'd1);
        check("t2_state_pause", 32'(state), 32'd2);
        check("t2_run", 32'(run), 32'd0);

        // 3: lap in RUN and back
        press(1'b1, 1'b0, 10);
        check("t3_state_run", 32'(state), 32'd1);
        lap0 = lap_cnt;
        btn_lap = 1'b1;
        tick(7);
        check("t3_state_lap", 32'(state), 32'd3);
        check("t3_lap_pulse", 32'(lap_pulse), 32'd1);
        check("t3_lap_hold", 32'(lap_hold), 32'd1);
        check("t3_run_in_lap", 32'(run), 32'd1);
        tick(1);
        check("t3_lap_pulse_end", 32'(lap_pulse), 32'd0);
        tick(2);
        btn_lap = 1'b0;
        tick(12);
        press(1'b0, 1'b1, 10);
        check("t3_back_run", 32'(state), 32'd1);
        check("t3_lap_hold_clr", 32'(lap_hold), 32'd0);
        check("t3_one_lap_pulse", 32'(lap_cnt - lap0), 32'd1);

        // 4: lap in PAUSE clears, lap in IDLE ignored
        press(1'b1, 1'b0, 10);
        check("t4_state_pause", 32'(state), 32'd2);
        clr0 = clr_cnt;
        lap0 = lap_cnt;
        btn_lap = 1'b1;
        tick(7);
        check("t4_state_idle", 32'(state), 32'd0);
        check("t4_clear_pulse", 32'(clear_pulse), 32'd1);
        tick(1);
        check("t4_clear_end", 32'(clear_pulse), 32'd0);
        tick(2);
        btn_lap = 1'b0;
        tick(12);
        press(1'b0, 1'b1, 10);
        check("t4_idle_lap_ignored", 32'(state), 32'd0);
        check("t4_clr_count", 32'(clr_cnt - clr0), 32'd1);
        check("t4_lap_count", 32'(lap_cnt - lap0), 32'd0);

        // 5: long press from RUN
        press(1'b1, 1'b0, 10);
        check("t5_state_run", 32'(state), 32'd1);
        clr0 = clr_cnt;
        tr0  = trans_cnt;
        btn_start = 1'b1;
        tick(7);
        check("t5_pause", 32'(state), 32'd2);
        tick(30);
        check("t5_before_long", 32'(state), 32'd2);
        check("t5_no_clear_yet", 32'(clr_cnt - clr0), 32'd0);
        tick(1);
        check("t5_long_idle", 32'(state), 32'd0);
        check("t5_long_clear", 32'(clear_pulse), 32'd1);
        tick(22);
        btn_start = 1'b0;
        tick(12);
        check("t5_one_clear", 32'(clr_cnt - clr0), 32'd1);
        check("t5_two_transitions", 32'(trans_cnt - tr0), 32'd2);
        check("t5_final_idle", 32'(state), 32'd0);

        // 6a: simultaneous start and lap in RUN
        press(1'b1, 1'b0, 10);
        lap0 = lap_cnt;
        btn_start = 1'b1;
        btn_lap   = 1'b1;
        tick(7);
        check("t6_pause", 32'(state), 32'd2);
        check("t6_no_lap_pulse", 32'(lap_pulse), 32'd0);
        tick(3);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        tick(12);
        check("t6_lap_dropped", 32'(lap_cnt - lap0), 32'd0);
        check("t6_still_pause", 32'(state), 32'd2);

        // 6b: asynchronous reset during a start debounce
        press(1'b1, 1'b0, 10);
        check("t6_run_again", 32'(state), 32'd1);
        btn_start = 1'b1;
        tick(3);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_state", 32'(state), 32'd0);
        check("t6_async_run", 32'(run), 32'd0);
        btn_start = 1'b0;
        tick(3);
        rst = 1'b1;
        clr0 = clr_cnt;
        lap0 = lap_cnt;
        tick(15);
        check("t6_post_reset_idle", 32'(state), 32'd0);
        check("t6_post_reset_pulses", 32'((clr_cnt - clr0) + (lap_cnt - lap0)), 32'd0);

        check("never_both_pulses", 32'(both_cnt), 32'd0);
        check("never_wide_pulse", 32'(wide_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
